// File: rtl/object_select_ctrl_if.sv
// Object-select bus: per-pixel draw requests in, object code and
// per-frame frog collision flags out.
interface object_select_ctrl_if;
    logic       startOfFrame;
    logic       active_video;
    logic       waterfall_dr;
    logic       log_dr;
    logic       frog_dr;
    logic       endbank_dr;
    logic       french_dr;
    logic       gate_a_dr;
    logic       gate_b_dr;
    logic [7:0] object_to_draw;
    logic       hit_water;
    logic       hit_log;
    logic       hit_endbank;
    logic       hit_french;
    logic       hit_gate;
    logic       collision_valid;

    // Video timing / object generators side
    modport master (
        output startOfFrame, active_video,
        output waterfall_dr, log_dr, frog_dr, endbank_dr,
        output french_dr, gate_a_dr, gate_b_dr,
        input  object_to_draw,
        input  hit_water, hit_log, hit_endbank, hit_french, hit_gate,
        input  collision_valid
    );

    // Object-select controller side
    modport slave (
        input  startOfFrame, active_video,
        input  waterfall_dr, log_dr, frog_dr, endbank_dr,
        input  french_dr, gate_a_dr, gate_b_dr,
        output object_to_draw,
        output hit_water, hit_log, hit_endbank, hit_french, hit_gate,
        output collision_valid
    );
endinterface

// File: rtl/object_select_ctrl.sv
// Object-select controller: resolves per-object draw requests into one
// registered priority code for the colour mux, and counts frog overlap
// pixels per frame, publishing latched hit flags at each start of frame.
module object_select_ctrl #(
    parameter int unsigned CNT_W         = 10,
    parameter int unsigned HIT_THRESHOLD = 4
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    object_select_ctrl_if.slave  bus
);

    typedef enum logic [7:0] {
        OBJ_BACKGROUND = 8'd0,
        OBJ_WATERFALL  = 8'd1,
        OBJ_LOG        = 8'd2,
        OBJ_FROG       = 8'd3,
        OBJ_ENDBANK    = 8'd4,
        OBJ_FRENCH     = 8'd5,
        OBJ_GATEA      = 8'd6,
        OBJ_GATEB      = 8'd7
    } obj_code_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

    localparam int unsigned NQ       = 5;
    localparam int unsigned Q_WATER  = 0;
    localparam int unsigned Q_LOG    = 1;
    localparam int unsigned Q_END    = 2;
    localparam int unsigned Q_FRENCH = 3;
    localparam int unsigned Q_GATE   = 4;

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(HIT_THRESHOLD);

    state_t                    state_q, state_d;
    obj_code_t                 code_q, code_d;
    logic [NQ-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NQ-1:0]             hit_q, hit_d;
    logic                      cv_q, cv_d;
    logic [NQ-1:0]             qual;
    logic                      frog_px;

    // Per-pixel overlap qualifiers, only meaningful on visible frog pixels
    always_comb begin
        frog_px        = bus.active_video & bus.frog_dr;
        qual           = '0;
        qual[Q_WATER]  = frog_px & bus.waterfall_dr & ~bus.log_dr;
        qual[Q_LOG]    = frog_px & bus.log_dr;
        qual[Q_END]    = frog_px & bus.endbank_dr;
        qual[Q_FRENCH] = frog_px & bus.french_dr;
        qual[Q_GATE]   = frog_px & (bus.gate_a_dr | bus.gate_b_dr);
    end

    // Fixed-priority object selection, forced to background while blanking
    always_comb begin
        code_d = OBJ_BACKGROUND;
        if (bus.active_video) begin
            if (bus.frog_dr)           code_d = OBJ_FROG;
            else if (bus.french_dr)    code_d = OBJ_FRENCH;
            else if (bus.gate_a_dr)    code_d = OBJ_GATEA;
            else if (bus.gate_b_dr)    code_d = OBJ_GATEB;
            else if (bus.log_dr)       code_d = OBJ_LOG;
            else if (bus.endbank_dr)   code_d = OBJ_ENDBANK;
            else if (bus.waterfall_dr) code_d = OBJ_WATERFALL;
            else                       code_d = OBJ_BACKGROUND;
        end
    end

    // Frame FSM: counter accumulation, SOF report and counter restart
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        cv_d    = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                cnt_d = '0;
                if (bus.startOfFrame) state_d = RUN;
            end
            RUN: begin
                for (int unsigned i = 0; i < NQ; i++) begin
                    if (bus.startOfFrame) begin
                        // Report the finished frame; the SOF pixel itself
                        // already counts toward the new frame.
                        hit_d[i] = (cnt_q[i] >= THRESH);
                        cnt_d[i] = qual[i] ? CNT_W'(1) : '0;
                    end else if (qual[i] && (cnt_q[i] != '1)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                if (bus.startOfFrame) cv_d = 1'b1;
            end
            default: begin
                state_d = WAIT_SOF;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters, flags and object code registers with sync reset
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= WAIT_SOF;
            code_q  <= OBJ_BACKGROUND;
            cnt_q   <= '0;
            hit_q   <= '0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            cv_q    <= cv_d;
        end
    end

    assign bus.object_to_draw  = code_q;
    assign bus.hit_water       = hit_q[Q_WATER];
    assign bus.hit_log         = hit_q[Q_LOG];
    assign bus.hit_endbank     = hit_q[Q_END];
    assign bus.hit_french      = hit_q[Q_FRENCH];
    assign bus.hit_gate        = hit_q[Q_GATE];
    assign bus.collision_valid = cv_q;

endmodule

// File: tb/tb_object_select_ctrl.sv
// Directed bench for object_select_ctrl (CNT_W=4 so saturation is reachable).
module tb_object_select_ctrl;

    logic CLK;
    logic RESETn;
    int   checks;
    int   errors;
    logic running;
    logic [7:0] q_code[$];
    logic       q_cv[$];

    object_select_ctrl_if bus ();

    object_select_ctrl #(
        .CNT_W         (4),
        .HIT_THRESHOLD (4)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] prio(input logic av, wf, lg, fr, eb, fh, ga, gb);
        if (!av) return 8'd0;
        if (fr)  return 8'd3;
        if (fh)  return 8'd5;
        if (ga)  return 8'd6;
        if (gb)  return 8'd7;
        if (lg)  return 8'd2;
        if (eb)  return 8'd4;
        if (wf)  return 8'd1;
        return 8'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_hits(input logic w, l, e, f, g);
        chk("hit_water",   {7'd0, bus.hit_water},   {7'd0, w});
        chk("hit_log",     {7'd0, bus.hit_log},     {7'd0, l});
        chk("hit_endbank", {7'd0, bus.hit_endbank}, {7'd0, e});
        chk("hit_french",  {7'd0, bus.hit_french},  {7'd0, f});
        chk("hit_gate",    {7'd0, bus.hit_gate},    {7'd0, g});
    endtask

    // One clock: drive inputs, push expectations, check after the edge
    task automatic step(input logic sof, av, wf, lg, fr, eb, fh, ga, gb);
        logic exp_cv;
        logic [7:0] e_code;
        logic       e_cv;
        bus.startOfFrame = sof;
        bus.active_video = av;
        bus.waterfall_dr = wf;
        bus.log_dr       = lg;
        bus.frog_dr      = fr;
        bus.endbank_dr   = eb;
        bus.french_dr    = fh;
        bus.gate_a_dr    = ga;
        bus.gate_b_dr    = gb;
        exp_cv = 1'b0;
        if (sof) begin
            exp_cv  = running;
            running = 1'b1;
        end
        q_code.push_back(prio(av, wf, lg, fr, eb, fh, ga, gb));
        q_cv.push_back(exp_cv);
        @(posedge CLK);
        #1;
        e_code = q_code.pop_front();
        e_cv   = q_cv.pop_front();
        chk("object_to_draw", bus.object_to_draw, e_code);
        chk("collision_valid", {7'd0, bus.collision_valid}, {7'd0, e_cv});
    endtask

    // n visible non-SOF pixels with the given requests
    task automatic px(input int n, input logic wf, lg, fr, eb, fh, ga, gb);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, wf, lg, fr, eb, fh, ga, gb);
    endtask

    task automatic sof_empty();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        step_inputs_zero();
        @(posedge CLK);
        #1;
        chk("rst_object_to_draw", bus.object_to_draw, 8'd0);
        chk("rst_collision_valid", {7'd0, bus.collision_valid}, 8'd0);
        check_hits(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        q_code.delete();
        q_cv.delete();
        running = 1'b0;
        RESETn  = 1'b1;
    endtask

    task automatic step_inputs_zero();
        bus.startOfFrame = 1'b0;
        bus.active_video = 1'b0;
        bus.waterfall_dr = 1'b0;
        bus.log_dr       = 1'b0;
        bus.frog_dr      = 1'b0;
        bus.endbank_dr   = 1'b0;
        bus.french_dr    = 1'b0;
        bus.gate_a_dr    = 1'b0;
        bus.gate_b_dr    = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        running = 1'b0;
        RESETn  = 1'b0;
        step_inputs_zero();
        @(posedge CLK);
        #1;
        do_reset();

        // Priority patterns (FSM still in WAIT_SOF)
        //   sof av wf lg fr eb fh ga gb
        step(0, 1, 1, 1, 1, 0, 0, 0, 0);   // frog over log+waterfall -> 3
        step(0, 1, 1, 1, 0, 0, 0, 0, 0);   // log wins over waterfall -> 2
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);   // nothing -> 0
        step(0, 1, 0, 0, 0, 0, 0, 1, 1);   // gate A over gate B -> 6
        step(0, 1, 0, 0, 0, 0, 1, 1, 0);   // french over gate A -> 5
        step(0, 1, 1, 0, 0, 1, 0, 0, 0);   // endbank over waterfall -> 4
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);   // waterfall -> 1
        step(0, 1, 0, 1, 0, 0, 0, 0, 1);   // gate B over log -> 7
        step(0, 0, 1, 1, 1, 1, 1, 1, 1);   // blanking -> 0
        // Frog+waterfall while waiting must not count
        px(6, 1, 0, 1, 0, 0, 0, 0);

        // First SOF after reset: enter RUN, no report
        sof_empty();
        check_hits(0, 0, 0, 0, 0);
        // Drowning at threshold
        px(4, 1, 0, 1, 0, 0, 0, 0);
        sof_empty();
        check_hits(1, 0, 0, 0, 0);
        // Three drowning pixels plus blanked pixels with every request high
        px(3, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, 1, 1, 1, 1);
        sof_empty();
        check_hits(0, 0, 0, 0, 0);
        // Log covers the waterfall
        px(10, 1, 1, 1, 0, 0, 0, 0);
        sof_empty();
        check_hits(0, 1, 0, 0, 0);
        // Flags hold through the frame
        px(5, 0, 0, 0, 0, 0, 0, 0);
        check_hits(0, 1, 0, 0, 0);
        sof_empty();
        check_hits(0, 0, 0, 0, 0);

        // SOF while blanking clears counters even with a qualifying request
        px(3, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 0, 0);
        check_hits(0, 0, 0, 0, 0);
        px(3, 1, 0, 1, 0, 0, 0, 0);
        sof_empty();
        check_hits(0, 0, 0, 0, 0);

        // SOF pixel belongs to the new frame
        px(3, 0, 0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 0, 1, 0, 0);
        check_hits(0, 0, 0, 0, 0);
        px(3, 0, 0, 1, 0, 1, 0, 0);
        sof_empty();
        check_hits(0, 0, 0, 1, 0);

        // Saturation: 40 and 48 pixels (48 would wrap to 0 on a 4-bit counter)
        px(40, 0, 0, 1, 0, 1, 0, 0);
        sof_empty();
        check_hits(0, 0, 0, 1, 0);
        px(48, 0, 0, 1, 0, 1, 0, 0);
        sof_empty();
        check_hits(0, 0, 0, 1, 0);
        px(2, 0, 0, 0, 0, 0, 0, 0);
        sof_empty();
        check_hits(0, 0, 0, 0, 0);

        // First frame after reset is never reported
        do_reset();
        px(5, 1, 0, 1, 0, 0, 0, 0);
        sof_empty();
        check_hits(0, 0, 0, 0, 0);
        px(20, 0, 0, 1, 0, 0, 0, 1);
        sof_empty();
        check_hits(0, 0, 0, 0, 1);

        // Reset mid-frame discards the partial counts
        px(30, 0, 0, 1, 1, 0, 0, 0);
        do_reset();
        sof_empty();
        check_hits(0, 0, 0, 0, 0);
        px(2, 0, 0, 0, 0, 0, 0, 0);
        sof_empty();
        check_hits(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
